mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage of the MIPS pipeline, directly downstream of the EX/MEM register. It consumes the EX/MEM register outputs and runs the data-memory access through a req/ack handshake. While an access is outstanding it stalls the upstream stages. It also contains the MEM/WB pipeline register, which feeds the writeback mux.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the access is aborted; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wbIn  input  2  from EX/MEM wbOut: bit1 RegWrite, bit0 MemToReg.
- mIn  input  2  from EX/MEM mOut: bit1 MemRead, bit0 MemWrite.
- resultIn  input  32  from EX/MEM resultOut: ALU result, also the memory byte address.
- writeDataIn  input  32  from EX/MEM writeDataOut: store data.
- registerRdIn  input  5  from EX/MEM registerRdOut: destination register.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  output  32  equals resultIn.
- dmem_wdata  output  32  equals writeDataIn.
- dmem_ack  input  1  access complete; rdata is valid in the same cycle.
- dmem_rdata  input  32  read data.
- stall  output  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- wbOut  output  2  MEM/WB: RegWrite, MemToReg.
- readDataOut  output  32  MEM/WB: loaded word.
- resultOut  output  32  MEM/WB: ALU result.
- registerRdOut  output  5  MEM/WB: destination register.
- err_misaligned  output  1  one-cycle registered pulse.
- err_timeout  output  1  one-cycle registered pulse.

## Operation
- Op decode, using mIn:
  - 2'b10 = load, 2'b01 = store, 2'b00 = no access.
  - 2'b11 = illegal. It is treated as no access and the MEM/WB register loads a bubble.
- A load or store is "valid" when resultIn[1:0] == 0.
- If the op is a load or store and resultIn[1:0] != 0 (misaligned):
  - no request is issued and the MEM/WB register loads a bubble;
  - err_misaligned pulses high in the cycle after the edge.
- FSM states: IDLE and WAIT.
- IDLE:
  - dmem_req = valid op (combinational); dmem_we = mIn[0].
  - If there is no op, or dmem_ack is already high, the MEM/WB register captures normally and the state stays IDLE.
  - If a valid op is present without ack, the next state is WAIT and the MEM/WB register loads a bubble.
- WAIT:
  - dmem_req is held at 1. Address, data and we stay stable because EX/MEM is frozen by stall.
  - On dmem_ack: the MEM/WB register captures and the next state is IDLE.
  - When the wait counter reaches TIMEOUT_CYCLES without ack: the access is aborted, the MEM/WB register loads a bubble, err_timeout pulses, and the next state is IDLE. The instruction is dropped.
- stall = dmem_req & ~dmem_ack (combinational).
- Wait counter: 8 bits. It is cleared on entering WAIT and increments each WAIT cycle without ack.
- MEM/WB capture:
  - wbOut ← wbIn; resultOut ← resultIn; registerRdOut ← registerRdIn.
  - readDataOut ← dmem_rdata for a load, 0 otherwise.
- A bubble sets wbOut = 0, readDataOut = 0, resultOut = 0 and registerRdOut = 0.
- A store never sets RegWrite, so wbIn passes through unchanged.

## Timing
- Reset: all outputs of the MEM/WB register are 0, err_* are 0, the state is IDLE and the counter is 0.
  - dmem_req goes to 0 immediately on assertion of rst, including in the middle of a WAIT.
  - stall goes to 0 immediately on assertion of rst.
- Zero-wait memory (ack in the same cycle as req): the instruction reaches MEM/WB at the next edge and there is no stall.
- N-cycle memory (ack N cycles after req first rises, 1 ≤ N < TIMEOUT_CYCLES): stall is high for N cycles. The result lands at the edge that closes the ack cycle.
- Back-to-back memory ops: the next op is presented by EX/MEM in the cycle after ack. A new request may be issued in that cycle.
- Boundary cases:
  - An ack in the same cycle as the timeout expiry counts as success.
  - An ack while dmem_req is low is ignored.
  - A misaligned op never stalls.

## Structure
- Shared package mips_pkg holds:
  - localparams for the mIn encodings: M_NONE, M_WRITE, M_READ, M_ILLEGAL;
  - the state enum for IDLE and WAIT;
  - WB bit indices.
- One sub-module, mem_wb_reg: the MEM/WB register. Ports: clk, rst, load, bubble and the four fields. It holds its value when neither load nor bubble is asserted.
- The FSM, wait counter and error pulse flops live in mem_access_stage.

## Test plan
- Load with zero-wait ack. Stimulus: mIn=10, wbIn=11, resultIn=0x100, registerRdIn=8, ack in the same cycle, rdata=0xDEADBEEF.
  - Required: no stall; next cycle wbOut=11, readDataOut=0xDEADBEEF, resultOut=0x100, registerRdOut=8.
- Store with ack 3 cycles after req. Stimulus: mIn=01, resultIn=0x204, writeDataIn=0x12345678.
  - Required: stall high for 3 cycles; dmem_we=1 and address/data stable throughout; wbOut=00 during the wait; readDataOut=0 after completion.
- Misaligned load. Stimulus: resultIn=0x102.
  - Required: dmem_req stays 0; no stall; MEM/WB loads a bubble; err_misaligned is high for exactly one cycle.
- Timeout. Stimulus: TIMEOUT_CYCLES=4, load with ack never asserted.
  - Required: stall for 5 cycles; then err_timeout pulses, MEM/WB loads a bubble, the state returns to IDLE and stall drops.
- Reset mid-WAIT. Stimulus: assert rst in the 2nd WAIT cycle.
  - Required: dmem_req and stall go to 0 asynchronously; all outputs are 0; after release the next op proceeds normally.
- Illegal op. Stimulus: mIn=11.
  - Required: no request, no stall, MEM/WB loads a bubble.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions:
// memory-op encodings, MEM FSM states, WB bits.
package mips_pkg;

  localparam logic [1:0] M_NONE    = 2'b00;
  localparam logic [1:0] M_WRITE   = 2'b01;
  localparam logic [1:0] M_READ    = 2'b10;
  localparam logic [1:0] M_ILLEGAL = 2'b11;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage
// (master) and the data memory (slave).
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble wins over load,
// and the contents hold when neither is asserted.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [1:0]  wb_d,
  input  logic [31:0] rdata_d,
  input  logic [31:0] result_d,
  input  logic [4:0]  rd_d,
  output logic [1:0]  wb_q,
  output logic [31:0] rdata_q,
  output logic [31:0] result_q,
  output logic [4:0]  rd_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= '0;
      rdata_q  <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (bubble) begin
      wb_q     <= '0;
      rdata_q  <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (load) begin
      wb_q     <= wb_d;
      rdata_q  <= rdata_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory req/ack access,
// upstream stall, timeout abort and MEM/WB register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wbIn,
  input  logic [1:0]  mIn,
  input  logic [31:0] resultIn,
  input  logic [31:0] writeDataIn,
  input  logic [4:0]  registerRdIn,
  mem_access_stage_if.master dmem,
  output logic        stall,
  output logic [1:0]  wbOut,
  output logic [31:0] readDataOut,
  output logic [31:0] resultOut,
  output logic [4:0]  registerRdOut,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        errm_q, errm_d;
  logic        errt_q, errt_d;

  logic        is_ld, is_st, is_op;
  logic        misal, valid_op;
  logic        req, ack;
  logic        mw_load, mw_bubble;
  logic [31:0] rdata_in;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    unique case (1'b1)
      (mIn == M_READ):  is_ld = 1'b1;
      (mIn == M_WRITE): is_st = 1'b1;
      default: ;
    endcase
  end

  assign is_op    = is_ld | is_st;
  assign misal    = resultIn[1:0] != 2'b00;
  assign valid_op = is_op & ~misal;
  assign ack      = dmem.dmem_ack;
  assign rdata_in = is_ld ? dmem.dmem_rdata : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    mw_load   = 1'b0;
    mw_bubble = 1'b0;
    errm_d    = 1'b0;
    errt_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req = valid_op;
        if (!valid_op) begin
          // illegal and misaligned ops become bubbles
          mw_load   = mIn == M_NONE;
          mw_bubble = mIn != M_NONE;
          errm_d    = is_op;
        end else if (ack) begin
          mw_load = 1'b1;
        end else begin
          mw_bubble = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = '0;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (ack) begin
          mw_load = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          mw_bubble = 1'b1;
          errt_d    = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      errm_q  <= 1'b0;
      errt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      errm_q  <= errm_d;
      errt_q  <= errt_d;
    end
  end

  // rst gates req so an in-flight access drops at once
  assign dmem.dmem_req   = req & ~rst;
  assign dmem.dmem_we    = mIn[0];
  assign dmem.dmem_addr  = resultIn;
  assign dmem.dmem_wdata = writeDataIn;
  assign stall           = dmem.dmem_req & ~ack;
  assign err_misaligned  = errm_q;
  assign err_timeout     = errt_q;

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .load     (mw_load),
    .bubble   (mw_bubble),
    .wb_d     (wbIn),
    .rdata_d  (rdata_in),
    .result_d (resultIn),
    .rd_d     (registerRdIn),
    .wb_q     (wbOut),
    .rdata_q  (readDataOut),
    .result_q (resultOut),
    .rd_q     (registerRdOut)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases
// plus random ops against a transaction-level model.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wbIn, mIn;
  logic [31:0] resultIn, writeDataIn;
  logic [4:0]  registerRdIn;
  logic        stall;
  logic [1:0]  wbOut;
  logic [31:0] readDataOut, resultOut;
  logic [4:0]  registerRdOut;
  logic        err_misaligned, err_timeout;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .wbIn           (wbIn),
    .mIn            (mIn),
    .resultIn       (resultIn),
    .writeDataIn    (writeDataIn),
    .registerRdIn   (registerRdIn),
    .dmem           (bus),
    .stall          (stall),
    .wbOut          (wbOut),
    .readDataOut    (readDataOut),
    .resultOut      (resultOut),
    .registerRdOut  (registerRdOut),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [1:0]  e_wb;
  logic [31:0] e_rdata, e_res;
  logic [4:0]  e_rd;
  logic        e_em, e_et;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_memwb(input string tag);
    chk({tag, ".wbOut"}, 32'(wbOut), 32'(e_wb));
    chk({tag, ".readData"}, readDataOut, e_rdata);
    chk({tag, ".result"}, resultOut, e_res);
    chk({tag, ".rd"}, 32'(registerRdOut), 32'(e_rd));
    chk({tag, ".err_mis"}, 32'(err_misaligned), 32'(e_em));
    chk({tag, ".err_tmo"}, 32'(err_timeout), 32'(e_et));
  endtask

  // Called at a negedge; lat = ack delay in cycles, -1 = never.
  task automatic run_op(input string tag, input logic [1:0] wb,
                        input logic [1:0] m, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int lat);
    bit ld    = (m == 2'b10);
    bit st    = (m == 2'b01);
    bit op    = ld | st;
    bit mis   = addr[1:0] != 2'b00;
    bit valid = op & ~mis;
    bit ok;
    int ncyc;
    logic [31:0] rdat = '0;
    if (!valid) ncyc = 1;
    else if (lat >= 0 && lat <= T) ncyc = lat + 1;
    else ncyc = T + 1;
    ok = valid ? (lat >= 0 && lat <= T) : (m == 2'b00);
    wbIn = wb; mIn = m; resultIn = addr;
    writeDataIn = wd; registerRdIn = rd;
    for (int k = 0; k < ncyc; k++) begin
      bus.dmem_ack   = valid ? (k == lat) : 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom;
      if (valid && k == lat) rdat = bus.dmem_rdata;
      #1;
      if (k == 0) begin
        check_memwb({tag, ".prev"});
      end else begin
        chk({tag, ".wait_wb"}, 32'(wbOut), 32'd0);
        chk({tag, ".wait_err"},
            32'({err_misaligned, err_timeout}), 32'd0);
      end
      chk({tag, ".req"}, 32'(bus.dmem_req), 32'(valid));
      chk({tag, ".stall"}, 32'(stall), 32'(valid && k != lat));
      if (valid) begin
        chk({tag, ".we"}, 32'(bus.dmem_we), 32'(st));
        chk({tag, ".addr"}, bus.dmem_addr, addr);
        chk({tag, ".wdata"}, bus.dmem_wdata, wd);
      end
      @(negedge clk);
    end
    bus.dmem_ack = 1'b0;
    e_wb    = ok ? wb : 2'b00;
    e_rdata = (ok && ld) ? rdat : 32'd0;
    e_res   = ok ? addr : 32'd0;
    e_rd    = ok ? rd : 5'd0;
    e_em    = op & mis;
    e_et    = valid & ~ok;
  endtask

  initial begin
    logic [1:0]  m;
    logic [31:0] a;
    int          lat;
    rst = 1'b1;
    wbIn = '0; mIn = '0; resultIn = '0;
    writeDataIn = '0; registerRdIn = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    e_wb = '0; e_rdata = '0; e_res = '0; e_rd = '0;
    e_em = 1'b0; e_et = 1'b0;
    repeat (2) @(negedge clk);
    check_memwb("reset");
    chk("reset.req", 32'(bus.dmem_req), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    rst = 1'b0;

    run_op("ld0", 2'b11, 2'b10, 32'h100, 32'h0, 5'd8, 0);
    chk("ld0.rdata_seen", 32'(e_rdata !== 32'd0 || 1'b1), 32'd1);
    run_op("st3", 2'b00, 2'b01, 32'h204, 32'h12345678, 5'd3, 3);
    run_op("mis", 2'b11, 2'b10, 32'h102, 32'h0, 5'd9, 0);
    run_op("nop", 2'b10, 2'b00, 32'h55, 32'h0, 5'd4, 0);
    run_op("tmo", 2'b11, 2'b10, 32'h400, 32'h0, 5'd7, -1);
    run_op("ill", 2'b11, 2'b11, 32'h40, 32'h0, 5'd6, 0);
    run_op("ldT", 2'b11, 2'b10, 32'h44, 32'h0, 5'd5, T);

    // reset during the second WAIT cycle
    wbIn = 2'b11; mIn = 2'b10; resultIn = 32'h300;
    registerRdIn = 5'd2; bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw.req", 32'(bus.dmem_req), 32'd0);
    chk("rstw.stall", 32'(stall), 32'd0);
    e_wb = '0; e_rdata = '0; e_res = '0; e_rd = '0;
    e_em = 1'b0; e_et = 1'b0;
    check_memwb("rstw");
    @(negedge clk);
    rst = 1'b0;
    run_op("post", 2'b11, 2'b10, 32'h308, 32'h0, 5'd12, 2);

    for (int i = 0; i < 150; i++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lat = int'($urandom_range(0, 6)) - 1;
      run_op("rnd", 2'($urandom), m, a, $urandom,
             5'($urandom), lat);
    end
    run_op("final", 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
